// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add controller: FSM state encoding
// and the default operand width.
package serial_add_pkg;

    // Default operand/result width in bits (must be >= 2).
    localparam int SERIAL_ADD_WIDTH = 4;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder. The serial controller time-multiplexes
// this single cell over all operand bits.
module serial_fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic c_o
);

    // Sum and carry of three input bits.
    always_comb begin
        s_o = a_i ^ b_i ^ cin_i;
        c_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add controller. Sequences one full-adder cell over WIDTH cycles,
// LSB first, and registers the WIDTH-bit sum and final carry.
// Optional feature: define SERIAL_ADD_SUB_EN to build in subtraction
// (sub=1 computes a-b mod 2^WIDTH, cout=1 meaning no borrow).
//
// Handshake: start is sampled only in IDLE or DONE; the edge that samples it
// high captures a, b and sub and moves to RUN. busy is high for exactly WIDTH
// cycles, then done pulses for one cycle while sum/cout hold the new result.
// start during RUN is ignored; back-to-back starts are accepted from DONE.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    state_e             state_q;
    logic [WIDTH-1:0]   a_sr_q;
    logic [WIDTH-1:0]   b_sr_q;
    logic [WIDTH-1:0]   s_sr_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;

    // Values loaded into the B shift register and carry flip-flop on accept.
    logic [WIDTH-1:0]   b_load_d;
    logic               carry_load_d;

    // Full-adder cell outputs for the current bit.
    logic               fa_s;
    logic               fa_c;

    // The LSB of the sum shift register is overwritten by the incoming bit
    // on the completion edge, so it is never read.
    logic               unused_s_lsb;
    assign unused_s_lsb = s_sr_q[0];

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction as a + ~b + 1: invert B and seed the carry with 1.
    always_comb begin
        b_load_d     = sub ? ~b : b;
        carry_load_d = sub;
    end
`else
    logic unused_sub;
    assign unused_sub = sub;

    // Addition only: operands load unchanged with a zero carry-in.
    always_comb begin
        b_load_d     = b;
        carry_load_d = 1'b0;
    end
`endif

    serial_fa_cell u_fa (
        .a_i   (a_sr_q[0]),
        .b_i   (b_sr_q[0]),
        .cin_i (carry_q),
        .s_o   (fa_s),
        .c_o   (fa_c)
    );

    // Controller FSM with its datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b_load_d;
                        carry_q <= carry_load_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_sr_q  <= {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_q  <= {1'b0, b_sr_q[WIDTH-1:1]};
                    s_sr_q  <= {fa_s, s_sr_q[WIDTH-1:1]};
                    carry_q <= fa_c;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        sum_q   <= {fa_s, s_sr_q[WIDTH-1:1]};
                        cout_q  <= fa_c;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
